// File: rtl/instr_rx_pkg.sv
// Shared encodings and default sizes for the instruction-load receiver.
// The optional ack timeout is enabled with the INSTR_RX_TIMEOUT_EN macro.
package instr_rx_pkg;

  localparam int IWIDTH_DEF  = 32;
  localparam int DEPTH_DEF   = 6;
  localparam int AWIDTH_DEF  = 3;
  localparam int TIMEOUT_DEF = 16;
  localparam int STATE_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/instr_rx_buf.sv
// Local instruction buffer: one write port and a registered read port.
// Reads outside the words stored in the current load return zero.
module instr_rx_buf
  import instr_rx_pkg::*;
#(
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              t_clk,
  input  logic              t_rst,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [IWIDTH-1:0] wr_data_i,
  input  logic [AWIDTH-1:0] rd_addr_i,
  input  logic [AWIDTH:0]   count_i,
  output logic [IWIDTH-1:0] rd_data_o
);

  logic [IWIDTH-1:0] mem_q [DEPTH];
  logic [IWIDTH-1:0] rdata_q;
  logic [IWIDTH-1:0] rdata_d;
  logic              rdValid;

  // Storage is deliberately not reset; only words below count are ever exposed.
  always_ff @(posedge t_clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rdValid = ({1'b0, rd_addr_i} < count_i);
  assign rdata_d = rdValid ? mem_q[rd_addr_i] : '0;

  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rd_data_o = rdata_q;

endmodule

// File: rtl/instr_receive.sv
// Requesting end of the instruction-load link: fills the buffer until the last word.
// Define INSTR_RX_TIMEOUT_EN to abort a load after TIMEOUT cycles without an ack.
module instr_receive
  import instr_rx_pkg::*;
#(
  parameter int IWIDTH  = IWIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int AWIDTH  = AWIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              t_clk,
  input  logic              t_rst,
  input  logic              r_i_start,
  output logic              r_o_syn,
  input  logic [IWIDTH-1:0] r_i_instr,
  input  logic              r_i_ack,
  input  logic              r_i_last,
  input  logic [AWIDTH-1:0] r_i_raddr,
  output logic [IWIDTH-1:0] r_o_rdata,
  output logic [AWIDTH:0]   r_o_count,
  output logic              r_o_done,
  output logic              r_o_err
);

  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);

  rx_state_e       state_q;
  logic            syn_q;
  logic            done_q;
  logic            err_q;
  logic [AWIDTH:0] count_q;
  logic [AWIDTH:0] count_d;
  logic            inReq;
  logic            room;
  logic            wrEn;
  logic            canStart;
  logic            timeout;

  assign inReq    = (state_q == ST_REQ);
  assign room     = (count_q < DEPTH_C);
  assign wrEn     = inReq & r_i_ack & room;
  assign canStart = r_i_start & ~inReq;
  assign count_d  = count_q + (AWIDTH+1)'(1);

`ifdef INSTR_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;

  assign tmo_d   = tmo_q + TW'(1);
  assign timeout = inReq & ~r_i_ack & (tmo_d == TW'(TIMEOUT));

  // Counts consecutive ack-less REQ cycles; any ack restarts the window.
  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      tmo_q <= '0;
    end else if (canStart || (inReq && r_i_ack)) begin
      tmo_q <= '0;
    end else if (inReq) begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // A last word still goes into the buffer on the same edge that raises done.
  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      state_q <= ST_IDLE;
      syn_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (r_i_ack && r_i_last) begin
            if (room) begin
              count_q <= count_d;
            end
            syn_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (r_i_ack && !room) begin
            syn_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end else if (r_i_ack) begin
            count_q <= count_d;
          end else if (timeout) begin
            syn_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end
        end
        default: begin
          if (r_i_start) begin
            state_q <= ST_REQ;
            syn_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
          end
        end
      endcase
    end
  end

  instr_rx_buf #(
    .IWIDTH (IWIDTH),
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_buf (
    .t_clk     (t_clk),
    .t_rst     (t_rst),
    .wr_en_i   (wrEn),
    .wr_addr_i (count_q[AWIDTH-1:0]),
    .wr_data_i (r_i_instr),
    .rd_addr_i (r_i_raddr),
    .count_i   (count_q),
    .rd_data_o (r_o_rdata)
  );

  assign r_o_syn   = syn_q;
  assign r_o_count = count_q;
  assign r_o_done  = done_q;
  assign r_o_err   = err_q;

endmodule

// File: tb/tb_instr_receive.sv
// Directed bench for instr_receive; the timeout step follows INSTR_RX_TIMEOUT_EN.
module tb_instr_receive;

  logic        t_clk = 1'b0;
  logic        t_rst = 1'b0;
  logic        r_i_start = 1'b0;
  logic        r_o_syn;
  logic [31:0] r_i_instr = '0;
  logic        r_i_ack = 1'b0;
  logic        r_i_last = 1'b0;
  logic [2:0]  r_i_raddr = '0;
  logic [31:0] r_o_rdata;
  logic [3:0]  r_o_count;
  logic        r_o_done;
  logic        r_o_err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] words [6];

  instr_receive dut (
    .t_clk     (t_clk),
    .t_rst     (t_rst),
    .r_i_start (r_i_start),
    .r_o_syn   (r_o_syn),
    .r_i_instr (r_i_instr),
    .r_i_ack   (r_i_ack),
    .r_i_last  (r_i_last),
    .r_i_raddr (r_i_raddr),
    .r_o_rdata (r_o_rdata),
    .r_o_count (r_o_count),
    .r_o_done  (r_o_done),
    .r_o_err   (r_o_err)
  );

  always #5 t_clk = ~t_clk;

  // Inputs change on the falling edge and are released after one rising edge.
  task automatic applyStimulus(input logic start, input logic ack, input logic last,
                               input logic [31:0] instr);
    r_i_start = start;
    r_i_ack   = ack;
    r_i_last  = last;
    r_i_instr = instr;
    @(posedge t_clk);
    @(negedge t_clk);
    r_i_start = 1'b0;
    r_i_ack   = 1'b0;
    r_i_last  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkStatus(input string tag, input logic expSyn, input logic expDone,
                             input logic expErr, input logic [3:0] expCount);
    checkOutput({tag, " syn/done/err/count"},
                {25'b0, r_o_syn, r_o_done, r_o_err, r_o_count},
                {25'b0, expSyn, expDone, expErr, expCount});
  endtask

  task automatic loadWords(input string tag, input logic [31:0] mask);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, (i == 5), words[i] ^ mask);
      checkStatus(tag, (i < 5), (i == 5), 1'b0, 4'(i + 1));
    end
  endtask

  task automatic readOne(input string tag, input logic [2:0] addr, input logic [31:0] expected);
    r_i_raddr = addr;
    @(posedge t_clk);
    @(negedge t_clk);
    checkOutput(tag, r_o_rdata, expected);
  endtask

  // Also confirms the read port is registered: a new address is not visible before the edge.
  task automatic readCheck(input string tag, input logic [31:0] mask);
    for (int i = 0; i < 6; i++) begin
      r_i_raddr = 3'(i);
      #1;
      if (i > 0) checkOutput({tag, "_latency"}, r_o_rdata, words[i-1] ^ mask);
      @(posedge t_clk);
      @(negedge t_clk);
      checkOutput(tag, r_o_rdata, words[i] ^ mask);
    end
  endtask

  initial begin
    logic [9:0] gapPat;
    int k;
    words[0] = 32'h20080005;
    words[1] = 32'h2009000A;
    words[2] = 32'h01095020;
    words[3] = 32'hAC0A0000;
    words[4] = 32'h8C0B0000;
    words[5] = 32'h0000000C;

    @(negedge t_clk);
    checkStatus("reset", 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("reset_rdata", r_o_rdata, 32'h0);
    t_rst = 1'b1;
    @(negedge t_clk);

    $display("[TB] step 1: back-to-back load");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkStatus("t1_start", 1'b1, 1'b0, 1'b0, 4'd0);
    loadWords("t1_load", 32'h0);
    readCheck("t1_read", 32'h0);

    $display("[TB] step 2: load with ack gaps");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkStatus("t2_start", 1'b1, 1'b0, 1'b0, 4'd0);
    gapPat = 10'b1101001101;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, gapPat[c], gapPat[c] && (k == 5), words[k % 6]);
      if (gapPat[c]) k++;
      checkStatus("t2_cycle", (k < 6), (k == 6), 1'b0, 4'(k));
    end
    readCheck("t2_read", 32'h0);

    $display("[TB] step 3: overflow");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkStatus("t3_start", 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'hA0000000 + 32'(i));
      checkStatus("t3_ack", (i < 6), 1'b0, (i == 6), (i < 6) ? 4'(i + 1) : 4'd6);
    end
    readOne("t3_read5", 3'd5, 32'hA0000005);

    $display("[TB] step 4: reset mid-load");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkStatus("t4_start", 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, words[i] ^ 32'h55550000);
    checkStatus("t4_three", 1'b1, 1'b0, 1'b0, 4'd3);
    t_rst = 1'b0;
    #1;
    checkStatus("t4_async", 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("t4_rdata", r_o_rdata, 32'h0);
    @(negedge t_clk);
    t_rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    loadWords("t4_load", 32'h0);
    readCheck("t4_read", 32'h0);

    $display("[TB] step 5: no ack");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkStatus("t5_start", 1'b1, 1'b0, 1'b0, 4'd0);
`ifdef INSTR_RX_TIMEOUT_EN
    repeat (15) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkStatus("t5_pre", 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkStatus("t5_timeout", 1'b0, 1'b0, 1'b1, 4'd0);
`else
    repeat (100) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkStatus("t5_wait", 1'b1, 1'b0, 1'b0, 4'd0);
`endif
    t_rst = 1'b0;
    #1;
    checkStatus("t5_reset", 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge t_clk);
    t_rst = 1'b1;

    $display("[TB] step 6: count-gated read and reload from done");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, words[i]);
    readOne("t6_gate5", 3'd5, 32'h0);
    readOne("t6_read2", 3'd2, words[2]);
    applyStimulus(1'b1, 1'b1, 1'b0, words[3]);
    checkStatus("t6_start_ignored", 1'b1, 1'b0, 1'b0, 4'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, words[4]);
    applyStimulus(1'b0, 1'b1, 1'b1, words[5]);
    checkStatus("t6_done", 1'b0, 1'b1, 1'b0, 4'd6);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkStatus("t6_restart", 1'b1, 1'b0, 1'b0, 4'd0);
    loadWords("t6_load2", 32'hFFFFFFFF);
    readCheck("t6_read2", 32'hFFFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
